// File: rtl/haar_wavelet_stack.sv
// Multi-level Haar wavelet engine: synchronised sample strobe feeds a chain of
// pairwise average/difference levels; one band at a time is driven to the output.
module haar_level #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         en_i,
  input  logic         stb_i,
  input  logic [W-1:0] val_i,
  output logic         stb_o,
  output logic [W-1:0] a_o,
  output logic [W-1:0] d_o
);
  logic         pending_q;
  logic [W-1:0] h_q, a_q, d_q;
  logic         stb_q;
  logic [W:0]        sum;
  logic signed [W:0] diff;

  assign sum  = {1'b0, h_q} + {1'b0, val_i};
  assign diff = $signed({1'b0, h_q}) - $signed({1'b0, val_i});

  always_ff @(posedge clk) begin
    if (!rstb) begin
      pending_q <= 1'b0;
      h_q       <= '0;
      a_q       <= '0;
      d_q       <= '0;
      stb_q     <= 1'b0;
    end else if (!en_i) begin
      // flush: partial pair and in-flight strobe are dropped, results hold
      pending_q <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      if (stb_i) begin
        if (pending_q) begin
          a_q       <= W'(sum >> 1);
          d_q       <= W'(diff >>> 1);
          pending_q <= 1'b0;
          stb_q     <= 1'b1;
        end else begin
          h_q       <= val_i;
          pending_q <= 1'b1;
        end
      end
    end
  end

  // stb_o doubles as the "a/d just written" flag for this level
  assign stb_o = stb_q;
  assign a_o   = a_q;
  assign d_o   = d_q;
endmodule

module haar_wavelet_stack #(
  parameter int DATA_WIDTH = 8,
  parameter int LEVELS     = 4,
  parameter int SEL_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  i_enable,
  input  logic                  i_data_clk,
  input  logic [DATA_WIDTH-1:0] i_value,
  input  logic [SEL_WIDTH-1:0]  i_select_output_channel,
  output logic [DATA_WIDTH-1:0] o_multiplexed_wavelet_out,
  output logic                  o_valid,
  output logic                  o_active
);
  localparam int W = DATA_WIDTH;

  logic         s1_q, s2_q, s3_q;
  logic [W-1:0] v1_q, v2_q;
  logic [1:0]   settle_q;
  logic         in_stb_q, x_wr_q;
  logic [W-1:0] x_q;
  logic [W-1:0] out_q, out_d;
  logic         vld_q, vld_d;
  logic         active_q;

  logic [LEVELS:0]              lvl_stb;
  logic [LEVELS:0][W-1:0]       lvl_val;
  logic [LEVELS-1:0][W-1:0]     lvl_d;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      v1_q     <= '0;
      v2_q     <= '0;
      settle_q <= '0;
      in_stb_q <= 1'b0;
      x_wr_q   <= 1'b0;
      x_q      <= '0;
      active_q <= 1'b0;
    end else begin
      s1_q     <= i_data_clk;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      v1_q     <= i_value;
      v2_q     <= v1_q;
      active_q <= 1'b1;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      // settle gate hides a strobe that was already high at reset release
      in_stb_q <= s2_q && !s3_q && (settle_q == 2'd3);
      x_wr_q   <= s2_q && !s3_q && (settle_q == 2'd3);
      if (s2_q && !s3_q && (settle_q == 2'd3)) x_q <= v2_q;
    end
  end

  assign lvl_stb[0] = in_stb_q;
  assign lvl_val[0] = x_q;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    haar_level #(.W(W)) u_lvl (
      .clk   (clk),
      .rstb  (rstb),
      .en_i  (i_enable),
      .stb_i (lvl_stb[k]),
      .val_i (lvl_val[k]),
      .stb_o (lvl_stb[k+1]),
      .a_o   (lvl_val[k+1]),
      .d_o   (lvl_d[k])
    );
  end

  always_comb begin
    out_d = '0;
    vld_d = 1'b0;
    for (int k = 0; k < LEVELS; k++) begin
      if (i_select_output_channel == SEL_WIDTH'(k)) begin
        out_d = lvl_d[k];
        vld_d = lvl_stb[k+1];
      end
    end
    if (i_select_output_channel == SEL_WIDTH'(LEVELS)) begin
      out_d = lvl_val[LEVELS];
      vld_d = lvl_stb[LEVELS];
    end
    if (i_select_output_channel == SEL_WIDTH'(LEVELS + 1)) begin
      out_d = x_q;
      vld_d = x_wr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign o_multiplexed_wavelet_out = out_q;
  assign o_valid                   = vld_q;
  assign o_active                  = active_q;
endmodule

// File: tb/tb_haar_wavelet_stack.sv
// Directed bench for haar_wavelet_stack with a per-sample behavioural model.
module tb_haar_wavelet_stack;
  localparam int W = 8;
  localparam int L = 4;
  localparam int S = 8;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         i_enable = 1'b1;
  logic         i_data_clk = 1'b0;
  logic [W-1:0] i_value = '0;
  logic [S-1:0] sel = '0;
  logic [W-1:0] o_out;
  logic         o_valid, o_active;

  int tests = 0;
  int fails = 0;
  int vcnt  = 0;
  int exp_v = 0;

  int m_a [L];
  int m_d [L];
  int m_h [L];
  bit m_p [L];
  int m_x;

  haar_wavelet_stack #(.DATA_WIDTH(W), .LEVELS(L), .SEL_WIDTH(S)) dut (
    .clk                       (clk),
    .rstb                      (rstb),
    .i_enable                  (i_enable),
    .i_data_clk                (i_data_clk),
    .i_value                   (i_value),
    .i_select_output_channel   (sel),
    .o_multiplexed_wavelet_out (o_out),
    .o_valid                   (o_valid),
    .o_active                  (o_active)
  );

  always #5 clk = ~clk;

  function automatic int exp_band(input int s);
    if (s < L) return m_d[s] & 255;
    if (s == L) return m_a[L-1];
    if (s == L + 1) return m_x;
    return 0;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < L; k++) begin
      m_a[k] = 0; m_d[k] = 0; m_h[k] = 0; m_p[k] = 0;
    end
    m_x = 0;
  endtask

  // Pairs cascade upward; a completed pair forwards its average to the next level.
  task automatic model_sample(input int v);
    int cur;
    m_x = v;
    if (int'(sel) == L + 1) exp_v++;
    cur = v;
    for (int k = 0; k < L; k++) begin
      if (!m_p[k]) begin
        m_h[k] = cur;
        m_p[k] = 1;
        break;
      end
      m_a[k] = (m_h[k] + cur) / 2;
      m_d[k] = (m_h[k] - cur) >>> 1;
      m_p[k] = 0;
      if (int'(sel) == k) exp_v++;
      if (k == L - 1 && int'(sel) == L) exp_v++;
      cur = m_a[k];
    end
  endtask

  always @(negedge clk) begin
    if (rstb && o_valid) begin
      vcnt++;
      check("valid_band", int'(o_out), exp_band(int'(sel)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    tick(3);
    model_clear();
    rstb = 1'b1;
    tick(5);
    vcnt = 0;
    exp_v = 0;
  endtask

  task automatic send(input int v);
    i_value = W'(v);
    model_sample(v);
    i_data_clk = 1'b1;
    tick(3);
    i_data_clk = 1'b0;
    tick(10);
  endtask

  task automatic set_sel(input int s);
    sel = S'(s);
    tick(2);
  endtask

  initial begin
    // reset with the strobe already high across release
    model_clear();
    i_data_clk = 1'b1;
    tick(3);
    check("rst_out", int'(o_out), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_active", int'(o_active), 0);
    rstb = 1'b1;
    tick(1);
    check("active_after_release", int'(o_active), 1);
    set_sel(L + 1);
    tick(6);
    check("no_edge_x", int'(o_out), 0);
    check("no_edge_valid_cnt", vcnt, 0);
    i_data_clk = 1'b0;
    tick(4);

    // basic pair
    set_sel(0);
    vcnt = 0; exp_v = 0;
    send(10); send(20);
    check("pair_d1", int'(o_out), 8'hFB);
    check("pair_d1_model", exp_band(0), 8'hFB);
    check("pair_valid_cnt", vcnt, 1);
    check("pair_valid_model", vcnt, exp_v);
    set_sel(L + 1);
    check("raw_x", int'(o_out), 20);

    // two levels
    set_sel(0);
    do_reset();
    send(10); send(20);
    check("lvl_d1_a", int'(o_out), 8'hFB);
    send(30); send(50);
    check("lvl_d1_b", int'(o_out), 8'hF6);
    check("lvl_d1_cnt", vcnt, 2);
    set_sel(1);
    check("lvl_d2", int'(o_out), 8'hF3);
    check("model_a2", m_a[1], 27);

    // extremes
    set_sel(0);
    do_reset();
    send(255); send(0);
    check("ext_d1_pos", int'(o_out), 8'h7F);
    check("model_a1_pos", m_a[0], 127);
    send(0); send(255);
    check("ext_d1_neg", int'(o_out), 8'h80);
    check("model_a1_neg", m_a[0], 127);
    set_sel(1);
    check("ext_d2", int'(o_out), 0);

    // constant input through all levels
    set_sel(L);
    do_reset();
    for (int i = 0; i < 16; i++) send(100);
    check("const_a4", int'(o_out), 100);
    check("const_valid_cnt", vcnt, 1);
    check("const_valid_model", vcnt, exp_v);
    for (int k = 0; k < L; k++) begin
      set_sel(k);
      check("const_d", int'(o_out), 0);
    end

    // flush discards the pending sample
    set_sel(0);
    do_reset();
    send(7);
    i_enable = 1'b0;
    for (int k = 0; k < L; k++) m_p[k] = 0;
    tick(2);
    i_enable = 1'b1;
    tick(1);
    send(40); send(60);
    check("flush_d1", int'(o_out), 8'hF6);
    check("flush_valid_cnt", vcnt, 1);
    check("flush_valid_model", vcnt, exp_v);

    // unmapped select
    set_sel(8'hFF);
    vcnt = 0; exp_v = 0;
    check("sel_ff_out", int'(o_out), 0);
    send(1); send(2);
    check("sel_ff_out_after", int'(o_out), 0);
    check("sel_ff_valid_cnt", vcnt, 0);
    check("active_run", int'(o_active), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
